// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: FSM states, transaction owner and access size codes.
package sram_req_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ADDR = 2'd1;
    localparam logic [1:0] ARB_DATA = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and memory-stage (data) requesters,
// one transaction at a time: grant -> address phase -> data phase.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              owner_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;

    logic              starve_hit_s;
    logic              grant_inst_s;
    logic              grant_data_s;
    logic              in_addr_s;
    logic              in_data_s;

    assign starve_hit_s = (starve_cnt_r == CNT_MAX);
    assign in_addr_s    = (state_r == ARB_ADDR);
    assign in_data_s    = (state_r == ARB_DATA);

    // Arbitration: data wins unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (state_r == ARB_IDLE) begin
            if (inst_req && data_req) begin
                if (starve_hit_s) begin
                    grant_inst_s = 1'b1;
                end else begin
                    grant_data_s = 1'b1;
                end
            end else if (inst_req) begin
                grant_inst_s = 1'b1;
            end else if (data_req) begin
                grant_data_s = 1'b1;
            end else begin
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_data_s = 1'b0;
        end
    end

    // Next-state logic; mem_data_ok only matters while in the data phase.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_inst_s || grant_data_s) begin
                    state_nxt_s = ARB_ADDR;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ADDR: begin
                if (mem_addr_ok) begin
                    state_nxt_s = ARB_DATA;
                end else begin
                    state_nxt_s = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (mem_data_ok) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_DATA;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ARB_IDLE;
            owner_r <= OWN_DATA;
        end else begin
            state_r <= state_nxt_s;
            if (grant_inst_s) begin
                owner_r <= OWN_INST;
            end else if (grant_data_s) begin
                owner_r <= OWN_DATA;
            end
        end
    end

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= '0;
        end else if (grant_inst_s) begin
            starve_cnt_r <= '0;
        end else if (grant_data_s && inst_req && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_ONE;
        end
    end

    // Request capture at grant; requester-side changes afterwards are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (grant_inst_s) begin
            wr_r    <= inst_wr;
            size_r  <= inst_size;
            addr_r  <= inst_addr;
            wdata_r <= inst_wdata;
        end else if (grant_data_s) begin
            wr_r    <= data_wr;
            size_r  <= data_size;
            addr_r  <= data_addr;
            wdata_r <= data_wdata;
        end
    end

    assign mem_req   = in_addr_s;
    assign mem_wr    = wr_r;
    assign mem_size  = size_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

    // Handshakes are routed combinationally so the requester sees them in the same cycle.
    assign inst_addr_ok = in_addr_s && (owner_r == OWN_INST) && mem_addr_ok;
    assign data_addr_ok = in_addr_s && (owner_r == OWN_DATA) && mem_addr_ok;
    assign inst_data_ok = in_data_s && (owner_r == OWN_INST) && mem_data_ok;
    assign data_data_ok = in_data_s && (owner_r == OWN_DATA) && mem_data_ok;

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    localparam int LIMIT = 4;
    localparam logic [31:0] IA = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    sram_req_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
        logic        e_req;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iaok;
        logic        e_idok;
        logic        e_daok;
        logic        e_ddok;
    } vec_t;

    vec_t vecs[12];

    // Reference model state (transaction level)
    bit          m_have, m_acc, m_own_data;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    int          m_starve;

    initial begin
        logic owners[6];
        int   n;
        bit   i_drop, d_drop, rst_now, g_inst, g_data;
        logic e_iaok, e_daok, e_idok, e_ddok;

        // data-only read, spurious handshakes in IDLE, then store-vs-fetch contention
        vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                     1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555AAAA,
                     1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, IA, 1'b1, 1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, IA, 1'b1, 1'b1, 32'h2000, 32'h12345678, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, IA, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D,
                     1'b0, 1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, IA, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, 32'h2000, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, IA, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b0, IA, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b0, IA, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, IA, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_wr", mem_wr, 1'b0);
        chk32("rst_mem_size", 32'(mem_size), 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_oks", inst_addr_ok | inst_data_ok | data_addr_ok | data_data_ok, 1'b0);
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            inst_req = vecs[i].ireq;   inst_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq;   data_wr = vecs[i].dwr;
            data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
            mem_addr_ok = vecs[i].maok; mem_data_ok = vecs[i].mdok; mem_rdata = vecs[i].mrdata;
            @(negedge clk);
            chk1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
            chk1($sformatf("v%0d_mem_wr", i), mem_wr, vecs[i].e_wr);
            chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk1($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok, vecs[i].e_iaok);
            chk1($sformatf("v%0d_inst_data_ok", i), inst_data_ok, vecs[i].e_idok);
            chk1($sformatf("v%0d_data_addr_ok", i), data_addr_ok, vecs[i].e_daok);
            chk1($sformatf("v%0d_data_data_ok", i), data_data_ok, vecs[i].e_ddok);
            if (vecs[i].e_req) chk32($sformatf("v%0d_mem_size", i), 32'(mem_size), 32'(SIZE_WORD));
            if (vecs[i].e_ddok) chk32($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].mrdata);
            if (vecs[i].e_idok) chk32($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].mrdata);
            next_cycle();
        end

        // starvation: both requesters held high, slave answers immediately
        idle_inputs();
        inst_req = 1'b1; inst_addr = IA;
        data_req = 1'b1; data_addr = 32'h4000;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) owners[k] = 1'b0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr_ok) begin
                owners[n] = (mem_addr != IA);
                n++;
            end
            next_cycle();
        end
        chk32("starve_grant_count", 32'(n), 32'd6);
        for (int k = 0; k < 6; k++)
            chk1($sformatf("starve_owner_is_data%0d", k), owners[k], 1'(k != 4));
        inst_req = 1'b0; data_req = 1'b0;
        next_cycle();
        idle_inputs();
        next_cycle();

        // stalled slave while the requester changes its address
        data_req = 1'b1; data_addr = 32'h2000;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            data_addr = 32'h3000;
            @(negedge clk);
            chk1($sformatf("stall%0d_mem_req", c), mem_req, 1'b1);
            chk32($sformatf("stall%0d_mem_addr", c), mem_addr, 32'h2000);
            chk1($sformatf("stall%0d_data_addr_ok", c), data_addr_ok, 1'b0);
            next_cycle();
        end
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk1("stall_accept_data_addr_ok", data_addr_ok, 1'b1);
        chk1("stall_accept_inst_addr_ok", inst_addr_ok, 1'b0);
        chk32("stall_accept_mem_addr", mem_addr, 32'h2000);
        next_cycle();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h600DD00D;
        @(negedge clk);
        chk1("stall_data_data_ok", data_data_ok, 1'b1);
        chk32("stall_data_rdata", data_rdata, 32'h600DD00D);
        next_cycle();
        idle_inputs();
        next_cycle();

        // reset in the data phase of an inst transaction
        inst_req = 1'b1; inst_addr = 32'h8000; mem_addr_ok = 1'b1;
        next_cycle();
        @(negedge clk);
        chk1("rstop_inst_addr_ok", inst_addr_ok, 1'b1);
        next_cycle();
        inst_req = 1'b0; reset = 1'b1;
        next_cycle();
        reset = 1'b0; mem_data_ok = 1'b1;
        @(negedge clk);
        chk1("rstop_inst_data_ok", inst_data_ok, 1'b0);
        chk1("rstop_mem_req", mem_req, 1'b0);
        chk32("rstop_mem_addr", mem_addr, 32'h0);
        next_cycle();
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk1("rstop_idle_mem_req", mem_req, 1'b0);
        chk1("rstop_idle_inst_addr_ok", inst_addr_ok, 1'b0);
        next_cycle();

        // randomized traffic against the reference model
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m_have = 1'b0; m_acc = 1'b0; m_own_data = 1'b1;
        m_wr = 1'b0; m_size = 2'd0; m_addr = 32'h0; m_wdata = 32'h0; m_starve = 0;
        i_drop = 1'b0; d_drop = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_now = ($urandom_range(299, 0) == 0);
            reset = rst_now;
            if (i_drop) inst_req = 1'b0;
            if (d_drop) data_req = 1'b0;
            if (!inst_req && $urandom_range(3, 0) == 0) begin
                inst_req = 1'b1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2, 0));
                inst_addr = $urandom; inst_wdata = $urandom;
            end else if (m_have && !m_acc && !m_own_data) begin
                inst_wr = 1'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(1, 0) == 0) begin
                data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom_range(2, 0));
                data_addr = $urandom; data_wdata = $urandom;
            end else if (m_have && !m_acc && m_own_data) begin
                data_size = 2'($urandom_range(2, 0)); data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = 1'($urandom);
            mem_data_ok = 1'($urandom);
            mem_rdata   = $urandom;
            @(negedge clk);
            e_iaok = m_have && !m_acc && !m_own_data && mem_addr_ok;
            e_daok = m_have && !m_acc &&  m_own_data && mem_addr_ok;
            e_idok = m_have &&  m_acc && !m_own_data && mem_data_ok;
            e_ddok = m_have &&  m_acc &&  m_own_data && mem_data_ok;
            chk1("rnd_mem_req", mem_req, m_have && !m_acc);
            chk1("rnd_mem_wr", mem_wr, m_wr);
            chk32("rnd_mem_size", 32'(mem_size), 32'(m_size));
            chk32("rnd_mem_addr", mem_addr, m_addr);
            chk32("rnd_mem_wdata", mem_wdata, m_wdata);
            chk1("rnd_inst_addr_ok", inst_addr_ok, e_iaok);
            chk1("rnd_data_addr_ok", data_addr_ok, e_daok);
            chk1("rnd_inst_data_ok", inst_data_ok, e_idok);
            chk1("rnd_data_data_ok", data_data_ok, e_ddok);
            chk32("rnd_inst_rdata", inst_rdata, mem_rdata);
            chk32("rnd_data_rdata", data_rdata, mem_rdata);
            i_drop = e_iaok;
            d_drop = e_daok;
            if (rst_now) begin
                m_have = 1'b0; m_acc = 1'b0; m_own_data = 1'b1; m_starve = 0;
                m_wr = 1'b0; m_size = 2'd0; m_addr = 32'h0; m_wdata = 32'h0;
                i_drop = 1'b1; d_drop = 1'b1;
            end else if (!m_have) begin
                g_inst = inst_req && (!data_req || m_starve == LIMIT);
                g_data = data_req && !g_inst;
                if (g_inst) begin
                    m_have = 1'b1; m_acc = 1'b0; m_own_data = 1'b0; m_starve = 0;
                    m_wr = inst_wr; m_size = inst_size; m_addr = inst_addr; m_wdata = inst_wdata;
                end else if (g_data) begin
                    m_have = 1'b1; m_acc = 1'b0; m_own_data = 1'b1;
                    if (inst_req && m_starve < LIMIT) m_starve++;
                    m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata;
                end
            end else if (!m_acc) begin
                if (mem_addr_ok) m_acc = 1'b1;
            end else begin
                if (mem_data_ok) m_have = 1'b0;
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
